// File: rtl/lane_vrf_write_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lane_vrf_write_arbiter_pkg                                                 |
// | Shared lane types: VRF write request payload and its field widths.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lane_vrf_write_arbiter_pkg;

  localparam int VD_W  = 5;
  localparam int OFF_W = 2;
  localparam int IDX_W = 3;

  // Same packing as the stage-3 write queue payload (47 bits).
  typedef struct packed {
    logic [VD_W-1:0]  vd;
    logic [OFF_W-1:0] offset;
    logic [3:0]       mask;
    logic [31:0]      data;
    logic             last;
    logic [IDX_W-1:0] instructionIndex;
  } vrf_write_req_t;

  function automatic logic is_null_beat(input vrf_write_req_t r);
    return (r.mask == 4'h0) && !r.last;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_vrf_write_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Combinational round-robin pick: first request at or after ptr, wrapping.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  logic             w_found;
  logic [PTR_W-1:0] w_cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = PTR_W'((int'(ptr_i) + k) % N);
      if (en_i && !w_found && req_i[w_cand]) begin
        w_found       = 1'b1;
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lane_vrf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lane_vrf_write_arbiter                                                     |
// | Round-robin merge of stage-3 slot writes into one registered VRF port.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lane_vrf_write_arbiter
  import lane_vrf_write_arbiter_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int VD_W  = lane_vrf_write_arbiter_pkg::VD_W,
  parameter int OFF_W = lane_vrf_write_arbiter_pkg::OFF_W,
  parameter int IDX_W = lane_vrf_write_arbiter_pkg::IDX_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SLOTS-1:0]       in_valid,
  output logic [SLOTS-1:0]       in_ready,
  input  logic [SLOTS*VD_W-1:0]  in_bits_vd,
  input  logic [SLOTS*OFF_W-1:0] in_bits_offset,
  input  logic [SLOTS*4-1:0]     in_bits_mask,
  input  logic [SLOTS*32-1:0]    in_bits_data,
  input  logic [SLOTS-1:0]       in_bits_last,
  input  logic [SLOTS*IDX_W-1:0] in_bits_instructionIndex,
  output logic                   vrfWrite_valid,
  input  logic                   vrfWrite_ready,
  output logic [VD_W-1:0]        vrfWrite_bits_vd,
  output logic [OFF_W-1:0]       vrfWrite_bits_offset,
  output logic [3:0]             vrfWrite_bits_mask,
  output logic [31:0]            vrfWrite_bits_data,
  output logic                   vrfWrite_bits_last,
  output logic [IDX_W-1:0]       vrfWrite_bits_instructionIndex,
  output logic                   lastReport_valid,
  output logic [IDX_W-1:0]       lastReport_instructionIndex
);

  localparam int PTR_W = $clog2(SLOTS);

  vrf_write_req_t   w_req [SLOTS];
  vrf_write_req_t   w_sel;
  logic [SLOTS-1:0] w_gnt;
  logic [PTR_W-1:0] w_win;
  logic             w_free, w_fire, w_deq;

  vrf_write_req_t   out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rep_valid_q, rep_valid_d;
  logic [IDX_W-1:0] rep_idx_q, rep_idx_d;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign w_req[i] = '{
      vd:               in_bits_vd[i*VD_W +: VD_W],
      offset:           in_bits_offset[i*OFF_W +: OFF_W],
      mask:             in_bits_mask[i*4 +: 4],
      data:             in_bits_data[i*32 +: 32],
      last:             in_bits_last[i],
      instructionIndex: in_bits_instructionIndex[i*IDX_W +: IDX_W]
    };
  end

  assign w_deq  = out_valid_q && vrfWrite_ready;
  assign w_free = !out_valid_q || vrfWrite_ready;

  rr_arbiter #(.N(SLOTS), .PTR_W(PTR_W)) u_rr (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .en_i  (w_free && !reset),
    .gnt_o (w_gnt),
    .idx_o (w_win)
  );

  assign in_ready = w_gnt;
  assign w_fire   = |w_gnt;
  assign w_sel    = w_req[w_win];

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    rep_valid_d = w_deq && out_q.last;
    rep_idx_d   = (w_deq && out_q.last) ? out_q.instructionIndex : rep_idx_q;
    if (w_deq) begin
      out_valid_d = 1'b0;
    end
    if (w_fire) begin
      ptr_d = (w_win == PTR_W'(SLOTS - 1)) ? '0 : w_win + 1'b1;
      // Null beats are consumed without occupying the output register.
      if (!is_null_beat(w_sel)) begin
        out_valid_d = 1'b1;
        out_d       = w_sel;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      rep_valid_q <= 1'b0;
      rep_idx_q   <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      rep_valid_q <= rep_valid_d;
      rep_idx_q   <= rep_idx_d;
    end
  end

  assign vrfWrite_valid                 = out_valid_q;
  assign vrfWrite_bits_vd               = out_q.vd;
  assign vrfWrite_bits_offset           = out_q.offset;
  assign vrfWrite_bits_mask             = out_q.mask;
  assign vrfWrite_bits_data             = out_q.data;
  assign vrfWrite_bits_last             = out_q.last;
  assign vrfWrite_bits_instructionIndex = out_q.instructionIndex;
  assign lastReport_valid               = rep_valid_q;
  assign lastReport_instructionIndex    = rep_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_vrf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lane_vrf_write_arbiter                                                  |
// | Directed stimulus with a scoreboard queue checked by a separate monitor.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lane_vrf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [19:0] in_bits_vd;
  logic [7:0]  in_bits_offset;
  logic [15:0] in_bits_mask;
  logic [127:0] in_bits_data;
  logic [3:0]  in_bits_last;
  logic [11:0] in_bits_instructionIndex;
  logic        vrfWrite_valid, vrfWrite_ready;
  logic [4:0]  o_vd;
  logic [1:0]  o_off;
  logic [3:0]  o_mask;
  logic [31:0] o_data;
  logic        o_last;
  logic [2:0]  o_idx;
  logic        lastReport_valid;
  logic [2:0]  lastReport_instructionIndex;

  logic [4:0]  s_vd   [4];
  logic [1:0]  s_off  [4];
  logic [3:0]  s_mask [4];
  logic [31:0] s_data [4];
  logic        s_last [4];
  logic [2:0]  s_idx  [4];

  logic [46:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        rep_exp = 1'b0;
  logic [2:0]  rep_idx_exp = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_bits_vd[i*5 +: 5]               = s_vd[i];
      in_bits_offset[i*2 +: 2]           = s_off[i];
      in_bits_mask[i*4 +: 4]             = s_mask[i];
      in_bits_data[i*32 +: 32]           = s_data[i];
      in_bits_last[i]                    = s_last[i];
      in_bits_instructionIndex[i*3 +: 3] = s_idx[i];
    end
  end

  lane_vrf_write_arbiter dut (
    .clock                          (clk),
    .reset                          (reset),
    .in_valid                       (in_valid),
    .in_ready                       (in_ready),
    .in_bits_vd                     (in_bits_vd),
    .in_bits_offset                 (in_bits_offset),
    .in_bits_mask                   (in_bits_mask),
    .in_bits_data                   (in_bits_data),
    .in_bits_last                   (in_bits_last),
    .in_bits_instructionIndex       (in_bits_instructionIndex),
    .vrfWrite_valid                 (vrfWrite_valid),
    .vrfWrite_ready                 (vrfWrite_ready),
    .vrfWrite_bits_vd               (o_vd),
    .vrfWrite_bits_offset           (o_off),
    .vrfWrite_bits_mask             (o_mask),
    .vrfWrite_bits_data             (o_data),
    .vrfWrite_bits_last             (o_last),
    .vrfWrite_bits_instructionIndex (o_idx),
    .lastReport_valid               (lastReport_valid),
    .lastReport_instructionIndex    (lastReport_instructionIndex)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int s, input logic [3:0] m, input logic [31:0] d,
                          input logic l, input logic [2:0] x);
    s_vd[s]   = 5'(s + 8);
    s_off[s]  = 2'(s);
    s_mask[s] = m;
    s_data[s] = d;
    s_last[s] = l;
    s_idx[s]  = x;
  endtask

  // One cycle: drive, check the hand-computed grant, queue the beat it should emit.
  task automatic cyc(input logic [3:0] v, input logic r, input logic [3:0] eg, input int ev);
    int w;
    in_valid       = v;
    vrfWrite_ready = r;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(eg));
    if (ev >= 0) chk("vrfWrite_valid", 64'(vrfWrite_valid), 64'(ev));
    if (eg != 4'b0) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) w = i;
      if (!(s_mask[w] == 4'h0 && !s_last[w]))
        exp_q.push_back({s_vd[w], s_off[w], s_mask[w], s_data[w], s_last[w], s_idx[w]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [46:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        rep_exp = 1'b0;
      end else begin
        chk("lastReport_valid", 64'(lastReport_valid), 64'(rep_exp));
        if (rep_exp) chk("lastReport_idx", 64'(lastReport_instructionIndex), 64'(rep_idx_exp));
        rep_exp = 1'b0;
        if (vrfWrite_valid && vrfWrite_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none",
                     {o_vd, o_off, o_mask, o_data, o_last, o_idx});
          end else begin
            e = exp_q.pop_front();
            chk("vrfWrite_beat", 64'({o_vd, o_off, o_mask, o_data, o_last, o_idx}), 64'(e));
            rep_exp     = e[3];
            rep_idx_exp = e[2:0];
          end
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    in_valid       = 4'hF;
    vrfWrite_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, 4'hF, 32'h10 + 32'(i), 1'b0, 3'(i));

    // Reset state: no grants while reset is asserted.
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_vrf_valid", 64'(vrfWrite_valid), 64'h0);
    chk("rst_report", 64'(lastReport_valid), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // All slots valid: 0,1,2,3,0,1 one per cycle.
    cyc(4'hF, 1'b1, 4'b0001, 0);
    cyc(4'hF, 1'b1, 4'b0010, 1);
    cyc(4'hF, 1'b1, 4'b0100, 1);
    cyc(4'hF, 1'b1, 4'b1000, 1);
    cyc(4'hF, 1'b1, 4'b0001, 1);
    cyc(4'hF, 1'b1, 4'b0010, 1);
    cyc(4'h0, 1'b1, 4'b0000, 1);
    cyc(4'h0, 1'b1, 4'b0000, 0);

    // ptr=2 -> slot 2 (ptr 3), then slot 2 again via wrap (ptr stays 3), then slot 3.
    set_slot(2, 4'h3, 32'h22, 1'b0, 3'd2);
    cyc(4'b0100, 1'b1, 4'b0100, 0);
    cyc(4'b0100, 1'b1, 4'b0100, 1);
    cyc(4'hF,    1'b1, 4'b1000, 1);
    cyc(4'h0,    1'b1, 4'b0000, 1);

    // Back-pressure: payload held, no grants, then dequeue+load with no gap.
    set_slot(0, 4'hF, 32'hA0, 1'b0, 3'd0);
    set_slot(1, 4'h5, 32'hB1, 1'b0, 3'd1);
    cyc(4'b0001, 1'b0, 4'b0001, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0010, 1'b0, 4'b0000, 1);
      chk("stall_data", 64'(o_data), 64'hA0);
    end
    cyc(4'b0010, 1'b1, 4'b0010, 1);
    cyc(4'h0,    1'b1, 4'b0000, 1);
    cyc(4'h0,    1'b1, 4'b0000, 0);

    // Null beat from slot 0 is consumed, never shown; ptr lands on 2.
    set_slot(0, 4'h0, 32'hDEAD, 1'b0, 3'd0);
    set_slot(1, 4'hF, 32'hC1, 1'b0, 3'd1);
    set_slot(2, 4'h1, 32'hC2, 1'b0, 3'd2);
    cyc(4'b0001, 1'b1, 4'b0001, 0);
    cyc(4'b0010, 1'b1, 4'b0010, 0);
    cyc(4'hF,    1'b1, 4'b0100, 1);
    cyc(4'h0,    1'b1, 4'b0000, 1);
    cyc(4'h0,    1'b1, 4'b0000, 0);

    // Last beats: idx 5 then a mask=0/last=1 beat idx 2, back-to-back reports.
    set_slot(3, 4'hF, 32'hE3, 1'b1, 3'd5);
    set_slot(0, 4'h0, 32'hE0, 1'b1, 3'd2);
    cyc(4'b1000, 1'b1, 4'b1000, 0);
    cyc(4'b0001, 1'b1, 4'b0001, 1);
    cyc(4'h0,    1'b1, 4'b0000, 1);
    cyc(4'h0,    1'b1, 4'b0000, 0);
    cyc(4'h0,    1'b1, 4'b0000, 0);

    // Reset while a last beat is held under back-pressure: discarded, no report.
    set_slot(1, 4'hF, 32'hF1, 1'b1, 3'd6);
    cyc(4'b0010, 1'b0, 4'b0010, 0);
    cyc(4'b0000, 1'b0, 4'b0000, 1);
    reset = 1'b1;
    cyc(4'hF, 1'b0, 4'b0000, 1);
    reset = 1'b0;
    exp_q.delete();
    set_slot(0, 4'hF, 32'h50, 1'b0, 3'd0);
    in_valid       = 4'h0;
    vrfWrite_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(vrfWrite_valid), 64'h0);
    chk("post_rst_report", 64'(lastReport_valid), 64'h0);
    @(posedge clk);
    #1;
    cyc(4'hF, 1'b1, 4'b0001, 0);
    cyc(4'h0, 1'b1, 4'b0000, 1);
    cyc(4'h0, 1'b1, 4'b0000, 0);
    cyc(4'h0, 1'b1, 4'b0000, 0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
